// File: rtl/l1c_inst_refill_master.sv
// AXI4 read master for L1 I-cache line refills: one INCR burst per miss, beats streamed to the cache.
// Optional sticky RRESP error capture is compiled in when REFILL_ERR_EN is defined.
module l1c_inst_refill_master #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 4,
   parameter int ID_W      = 4,
   parameter int AXI_ID    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              I_req,
   input  logic [ADDR_W-1:0] I_addr,
   output logic [DATA_W-1:0] I_out,
   output logic              cache_rvalid,
   output logic              cache_rlast,
   output logic              refill_busy,
   output logic [ID_W-1:0]   ARID,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [3:0]        ARLEN,
   output logic [2:0]        ARSIZE,
   output logic [1:0]        ARBURST,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY
`ifdef REFILL_ERR_EN
   ,
   input  logic              err_clr,
   output logic              refill_err,
   output logic [ADDR_W-1:0] refill_err_addr
`endif
);

   localparam int LINE_BYTES = BURST_LEN * DATA_W / 8;
   localparam int OFF_W      = $clog2(LINE_BYTES);
   localparam int CNT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AR   = 2'd1,
      ST_R    = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [CNT_W-1:0]  beat_cnt;
   logic              beat;

   assign ARID    = ID_W'(AXI_ID);
   assign ARLEN   = 4'(BURST_LEN - 1);
   assign ARSIZE  = 3'($clog2(DATA_W / 8));
   assign ARBURST = 2'b01;
   assign ARADDR  = addr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         addr_reg  <= '0;
         beat_cnt  <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && I_req) begin
            addr_reg <= {I_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            beat_cnt <= '0;
         end else if (beat && beat_cnt != CNT_MAX) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      ARVALID      = 1'b0;
      RREADY       = 1'b0;
      beat         = 1'b0;
      I_out        = '0;
      cache_rvalid = 1'b0;
      cache_rlast  = 1'b0;
      case (state_reg)
         ST_IDLE: if (I_req) state_next = ST_AR;
         ST_AR: begin
            ARVALID = 1'b1;
            if (ARREADY) state_next = ST_R;
         end
         ST_R: begin
            // RLAST, not the beat count, decides when the line is complete.
            RREADY       = 1'b1;
            beat         = RVALID;
            cache_rvalid = RVALID;
            cache_rlast  = RVALID & RLAST;
            if (RVALID) I_out = RDATA;
            if (RVALID && RLAST) state_next = ST_DONE;
         end
         ST_DONE: if (!I_req) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign refill_busy = (state_reg != ST_IDLE);

`ifdef REFILL_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refill_err      <= 1'b0;
         refill_err_addr <= '0;
      end else if (beat && RRESP != 2'b00) begin
         // A clear in the same cycle as a new error re-arms capture for that error.
         if (!refill_err || err_clr) refill_err_addr <= addr_reg;
         refill_err <= 1'b1;
      end else if (err_clr) begin
         refill_err      <= 1'b0;
         refill_err_addr <= '0;
      end
   end

   logic unused_bits;
   assign unused_bits = ^I_addr[OFF_W-1:0];
`else
   logic unused_bits;
   assign unused_bits = ^{I_addr[OFF_W-1:0], RRESP};
`endif

endmodule

// File: tb/tb_l1c_inst_refill_master.sv
// Directed self-checking bench for l1c_inst_refill_master; define REFILL_ERR_EN to cover error capture.
module tb_l1c_inst_refill_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        I_req = 1'b0;
   logic [31:0] I_addr = '0;
   logic [31:0] I_out;
   logic        cache_rvalid, cache_rlast, refill_busy;
   logic [3:0]  ARID;
   logic [31:0] ARADDR;
   logic [3:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        ARVALID;
   logic        ARREADY = 1'b0;
   logic [31:0] RDATA = '0;
   logic [1:0]  RRESP = '0;
   logic        RLAST = 1'b0;
   logic        RVALID = 1'b0;
   logic        RREADY;
`ifdef REFILL_ERR_EN
   logic        err_clr = 1'b0;
   logic        refill_err;
   logic [31:0] refill_err_addr;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int n_rv     = 0;
   int rv_start;

   l1c_inst_refill_master dut (
      .clk(clk), .rst(rst), .I_req(I_req), .I_addr(I_addr), .I_out(I_out),
      .cache_rvalid(cache_rvalid), .cache_rlast(cache_rlast), .refill_busy(refill_busy),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .RVALID(RVALID), .RREADY(RREADY)
`ifdef REFILL_ERR_EN
      , .err_clr(err_clr), .refill_err(refill_err), .refill_err_addr(refill_err_addr)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (cache_rvalid) n_rv <= n_rv + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   // Issues a request and completes the AR handshake; wait_cycles=0 means ARREADY is already high.
   task automatic ar_phase(input logic [31:0] addr, input logic [31:0] line, input int wait_cycles);
      I_req   = 1'b1;
      I_addr  = addr;
      ARREADY = (wait_cycles == 0);
      @(negedge clk);
      I_addr = 32'hFFFF_FFFF;
      for (int w = 0; w < wait_cycles; w++) begin
         #1;
         check_eq("ar_wait_valid", ARVALID, 1);
         check_eq("ar_wait_addr", ARADDR, line);
         @(negedge clk);
      end
      ARREADY = 1'b1;
      #1;
      check_eq("ar_valid", ARVALID, 1);
      check_eq("ar_addr", ARADDR, line);
      check_eq("ar_len", ARLEN, 3);
      check_eq("ar_size", ARSIZE, 2);
      check_eq("ar_burst", ARBURST, 1);
      check_eq("ar_id", ARID, 0);
      check_eq("ar_rready_low", RREADY, 0);
      @(negedge clk);
      ARREADY = 1'b0;
      #1;
      check_eq("r_rready", RREADY, 1);
      check_eq("r_arvalid_low", ARVALID, 0);
   endtask

   task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] resp);
      RVALID = 1'b1;
      RDATA  = d;
      RLAST  = last;
      RRESP  = resp;
      #1;
      check_eq("beat_data", I_out, d);
      check_eq("beat_valid", cache_rvalid, 1);
      check_eq("beat_last", cache_rlast, last);
      @(negedge clk);
      RVALID = 1'b0;
      RLAST  = 1'b0;
      RDATA  = '0;
      RRESP  = '0;
   endtask

   // RLAST and junk data are held high during bubbles; neither may leak to the cache.
   task automatic bubbles(input int n);
      for (int b = 0; b < n; b++) begin
         RDATA = 32'hDEAD_BEEF;
         RLAST = 1'b1;
         #1;
         check_eq("bubble_valid", cache_rvalid, 0);
         check_eq("bubble_data", I_out, 0);
         check_eq("bubble_last", cache_rlast, 0);
         @(negedge clk);
         RDATA = '0;
         RLAST = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("rst_busy", refill_busy, 0);
      check_eq("rst_arvalid", ARVALID, 0);
      check_eq("rst_araddr", ARADDR, 0);
      check_eq("rst_arid", ARID, 0);
      check_eq("rst_arlen", ARLEN, 3);
      check_eq("rst_arsize", ARSIZE, 2);
      check_eq("rst_arburst", ARBURST, 1);
      check_eq("rst_rready", RREADY, 0);
`ifdef REFILL_ERR_EN
      check_eq("rst_err", refill_err, 0);
      check_eq("rst_err_addr", refill_err_addr, 0);
`endif
      @(negedge clk);
      rst = 1'b0;

      // 1: unaligned address, ARREADY two cycles late, four back-to-back beats
      ar_phase(32'h0000_1234, 32'h0000_1230, 2);
      beat(32'hA0, 1'b0, 2'b00);
      beat(32'hA1, 1'b0, 2'b00);
      beat(32'hA2, 1'b0, 2'b00);
      beat(32'hA3, 1'b1, 2'b00);
      #1;
      check_eq("done_busy", refill_busy, 1);
      check_eq("done_rready", RREADY, 0);

      // 3: I_req held after completion -> stay DONE, no reissue, nothing forwarded
      for (int c = 0; c < 5; c++) begin
         RVALID = 1'b1;
         RDATA  = 32'h5555_AAAA;
         #1;
         check_eq("hold_arvalid", ARVALID, 0);
         check_eq("hold_rvalid", cache_rvalid, 0);
         check_eq("hold_busy", refill_busy, 1);
         @(negedge clk);
      end
      RVALID = 1'b0;
      RDATA  = '0;
      I_req  = 1'b0;
      @(negedge clk);
      #1;
      check_eq("idle_busy", refill_busy, 0);

      // 6 + 2: ARREADY pre-asserted, beats separated by 3-cycle bubbles
      ar_phase(32'h0000_0040, 32'h0000_0040, 0);
      rv_start = n_rv;
      beat(32'hB0, 1'b0, 2'b00);
      bubbles(3);
      beat(32'hB1, 1'b0, 2'b00);
      bubbles(3);
      beat(32'hB2, 1'b0, 2'b00);
      bubbles(3);
      beat(32'hB3, 1'b1, 2'b00);
      check_eq("rvalid_count", n_rv - rv_start, 4);
      I_req = 1'b0;
      @(negedge clk);

      // 4: I_req drop during R is ignored; async reset after beat 2 aborts the burst
      ar_phase(32'h0000_5010, 32'h0000_5010, 1);
      I_req = 1'b0;
      beat(32'hE0, 1'b0, 2'b00);
      beat(32'hE1, 1'b0, 2'b00);
      #1;
      check_eq("drop_rready", RREADY, 1);
      RVALID = 1'b1;
      RDATA  = 32'h1234_5678;
      rst    = 1'b1;
      #1;
      check_eq("arst_busy", refill_busy, 0);
      check_eq("arst_rready", RREADY, 0);
      check_eq("arst_rvalid", cache_rvalid, 0);
      check_eq("arst_data", I_out, 0);
      check_eq("arst_araddr", ARADDR, 0);
      @(negedge clk);
      rst    = 1'b0;
      RVALID = 1'b0;
      RDATA  = '0;

      // post-reset refill, early RLAST on the second beat ends the line
      ar_phase(32'h0000_2008, 32'h0000_2000, 1);
      I_req = 1'b0;
      beat(32'hC0, 1'b0, 2'b00);
      beat(32'hC1, 1'b1, 2'b00);
      #1;
      check_eq("early_done_busy", refill_busy, 1);
      check_eq("early_done_rready", RREADY, 0);
      @(negedge clk);
      #1;
      check_eq("early_idle_busy", refill_busy, 0);

`ifdef REFILL_ERR_EN
      // 5: SLVERR on beat 2 is captured, data still forwarded, err_clr clears
      ar_phase(32'h0000_4444, 32'h0000_4440, 1);
      beat(32'hD0, 1'b0, 2'b00);
      beat(32'hD1, 1'b0, 2'b00);
      check_eq("err_before", refill_err, 0);
      beat(32'hD2, 1'b0, 2'b10);
      check_eq("err_set", refill_err, 1);
      check_eq("err_addr", refill_err_addr, 32'h0000_4440);
      beat(32'hD3, 1'b1, 2'b00);
      check_eq("err_sticky", refill_err, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      check_eq("err_clr", refill_err, 0);
      check_eq("err_clr_addr", refill_err_addr, 0);
      I_req = 1'b0;
      @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
